// File: rtl/shift_left_seq.sv
// Multi-cycle left shift / rotate-left unit: one bit position per clock,
// single-cycle done pulse with the result held until the next completion.
module shift_left_seq #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [SHAMT_W-1:0] amnt,
   input  logic               rotate,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               rot_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         rot_q   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         unique case (state_q)
            // FINISH accepts start exactly like IDLE so operations can run back to back.
            StIdle, StFinish: begin
               done <= 1'b0;
               if (start) begin
                  data_q  <= A;
                  cnt_q   <= amnt;
                  rot_q   <= rotate;
                  busy    <= 1'b1;
                  state_q <= StShift;
               end else begin
                  state_q <= StIdle;
               end
            end
            StShift: begin
               if (cnt_q != '0) begin
                  data_q <= rot_q ? {data_q[WIDTH-2:0], data_q[WIDTH-1]}
                                  : {data_q[WIDTH-2:0], 1'b0};
                  cnt_q  <= cnt_q - 1'b1;
               end else begin
                  result  <= data_q;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StFinish;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed self-checking bench for shift_left_seq.
module tb_shift_left_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] a;
   logic [4:0]  amnt;
   logic        rotate;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   shift_left_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .A      (a),
      .amnt   (amnt),
      .rotate (rotate),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Launches one operation and waits (bounded) for done; inputs are scrambled after accept.
   // Returns at #1 after the done edge; lat=-1 on timeout.
   task automatic run_op(input logic [31:0] av, input logic [4:0] nv, input logic rv,
                         output int lat, output int bcyc, output logic [31:0] res);
      @(posedge clk); #1;
      a = av; amnt = nv; rotate = rv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~av; amnt = ~nv; rotate = ~rv;
      lat = -1; bcyc = 0; res = 'x;
      for (int k = 1; k <= 40; k++) begin
         if (busy) bcyc++;
         @(posedge clk); #1;
         if (done) begin
            lat = k; res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; a = '0; amnt = '0; rotate = 1'b0;
      #23;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
      reset_n = 1'b1;
   endtask

   task automatic test_shift_max();
      int lat, bcyc; logic [31:0] res;
      run_op(32'h0000_0001, 5'd31, 1'b0, lat, bcyc, res);
      total++; if (lat !== 32) begin bad++; $display("FAIL max_latency got=%0d want=32", lat); end
      total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL max_result got=%h want=80000000", res); end
      total++; if (bcyc !== 32) begin bad++; $display("FAIL max_busy_cycles got=%0d want=32", bcyc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_busy_in_done got=%b want=0", busy); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_width got=%b want=0", done); end
   endtask

   task automatic test_zero_and_fill();
      int lat, bcyc; logic [31:0] res;
      run_op(32'hDEAD_BEEF, 5'd0, 1'b0, lat, bcyc, res);
      total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
      total++; if (res !== 32'hDEAD_BEEF) begin bad++; $display("FAIL zero_result got=%h want=deadbeef", res); end
      run_op(32'hFFFF_FFFF, 5'd4, 1'b0, lat, bcyc, res);
      total++; if (lat !== 5) begin bad++; $display("FAIL fill_latency got=%0d want=5", lat); end
      total++; if (res !== 32'hFFFF_FFF0) begin bad++; $display("FAIL fill_result got=%h want=fffffff0", res); end
   endtask

   task automatic test_rotate();
      int lat, bcyc; logic [31:0] res;
      run_op(32'h8000_0001, 5'd4, 1'b1, lat, bcyc, res);
      total++; if (res !== 32'h0000_0018) begin bad++; $display("FAIL rot4_result got=%h want=00000018", res); end
      run_op(32'h1234_5678, 5'd8, 1'b1, lat, bcyc, res);
      total++; if (res !== 32'h3456_7812) begin bad++; $display("FAIL rot8_result got=%h want=34567812", res); end
      total++; if (lat !== 9) begin bad++; $display("FAIL rot8_latency got=%0d want=9", lat); end
      repeat (5) @(posedge clk);
      #1;
      total++; if (result !== 32'h3456_7812) begin bad++; $display("FAIL rot_hold got=%h want=34567812", result); end
   endtask

   task automatic test_ignore_busy();
      int dones = 0;
      int lat = -1;
      @(posedge clk); #1;
      a = 32'h0000_0003; amnt = 5'd6; rotate = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 2) begin a = 32'hFFFF_FFFF; amnt = 5'd1; rotate = 1'b1; start = 1'b1; end
         if (k == 3) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (lat < 0) lat = k;
            total++; if (result !== 32'h0000_00C0) begin bad++; $display("FAIL ignore_result got=%h want=000000c0", result); end
         end
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
      total++; if (lat !== 7) begin bad++; $display("FAIL ignore_latency got=%0d want=7", lat); end
   endtask

   task automatic test_abort();
      int dones = 0;
      int lat, bcyc; logic [31:0] res;
      @(posedge clk); #1;
      a = 32'h0000_0001; amnt = 5'd10; rotate = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h want=0", result); end
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
      run_op(32'h0000_0003, 5'd2, 1'b0, lat, bcyc, res);
      total++; if (res !== 32'h0000_000C) begin bad++; $display("FAIL abort_next_result got=%h want=0000000c", res); end
      total++; if (lat !== 3) begin bad++; $display("FAIL abort_next_latency got=%0d want=3", lat); end
   endtask

   task automatic test_back_to_back();
      int lat1, bcyc, sep;
      logic [31:0] res1;
      run_op(32'h0000_000F, 5'd3, 1'b0, lat1, bcyc, res1);
      total++; if (res1 !== 32'h0000_0078) begin bad++; $display("FAIL b2b_first_result got=%h want=00000078", res1); end
      // Present the second op in the done cycle of the first.
      a = 32'hF000_0001; amnt = 5'd2; rotate = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
      start = 1'b0; a = '0; amnt = '0; rotate = 1'b0;
      sep = -1;
      for (int k = 2; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin sep = k; break; end
      end
      total++; if (sep !== 4) begin bad++; $display("FAIL b2b_done_spacing got=%0d want=4", sep); end
      total++; if (result !== 32'hC000_0007) begin bad++; $display("FAIL b2b_second_result got=%h want=c0000007", result); end
   endtask

   initial begin
      test_reset();
      test_shift_max();
      test_zero_and_fill();
      test_rotate();
      test_ignore_busy();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
